// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared types, default sizing and helpers for the correlation engine
package corr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACC,
        EMIT,
        DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int DEF_N_A    = 20;
    localparam int DEF_N_B    = 5000;
    localparam int DEF_DATA_W = 8;
    localparam int PROD_W     = 2 * DEF_DATA_W;
    localparam int N_LAGS     = DEF_N_B - DEF_N_A + 1;
    // 8 guard bits hold the sum of up to 256 full-scale products
    localparam int DEF_ACC_W  = PROD_W + 8;
    localparam logic [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/corr_peak_tracker.sv
// rtl/corr_peak_tracker.sv - running signed maximum of correlation values and its lag
module corr_peak_tracker
    import corr_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int LAG_W = 13,
    parameter logic [ACC_W-1:0] RST_VAL = ACC_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [ACC_W-1:0] value,
    input  logic [LAG_W-1:0] lag,
    output logic [ACC_W-1:0] peak_val,
    output logic [LAG_W-1:0] peak_lag
);

    // strict compare: on a tie the earlier lag is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_val <= RST_VAL;
            peak_lag <= '0;
        end else if (upd && ($signed(value) > $signed(peak_val))) begin
            peak_val <= value;
            peak_lag <= lag;
        end
    end

endmodule

// File: rtl/corr_mac.sv
// rtl/corr_mac.sv - per-lag multiply-accumulate correlator paced against the sample ROM
module corr_mac
    import corr_pkg::*;
#(
    parameter int N_A    = DEF_N_A,
    parameter int N_B    = DEF_N_B,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LAG_W  = clog2(N_LAGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              next_add,
    output logic              corr_valid,
    output logic [ACC_W-1:0]  corr_out,
    output logic [LAG_W-1:0]  corr_lag,
    output logic [ACC_W-1:0]  peak_val,
    output logic [LAG_W-1:0]  peak_lag,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = clog2(N_A + 1);
    localparam int P_W   = 2 * DATA_W;
    localparam logic [LAG_W-1:0] LAST_LAG = LAG_W'(N_B - N_A);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_A);

    state_t                  state, state_n;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        sample_cnt;
    logic [LAG_W-1:0]        lag;
    logic                    take, acc_step, emit, req, err_set;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // with ena_in low every control strobe stays idle, so all state holds
    always_comb begin
        state_n  = state;
        take     = 1'b0;
        acc_step = 1'b0;
        emit     = 1'b0;
        req      = 1'b0;
        err_set  = 1'b0;
        if (ena_in) begin
            case (state)
                IDLE: begin
                    err_set = in_valid;
                    state_n = WAIT;
                end
                WAIT: begin
                    if (in_valid) begin
                        take    = 1'b1;
                        state_n = ACC;
                    end
                end
                ACC: begin
                    acc_step = 1'b1;
                    err_set  = in_valid;
                    if (sample_cnt == CNT_FULL) begin
                        state_n = EMIT;
                    end else begin
                        req     = 1'b1;
                        state_n = WAIT;
                    end
                end
                EMIT: begin
                    emit    = 1'b1;
                    err_set = in_valid;
                    if (lag == LAST_LAG) begin
                        state_n = DONE;
                    end else begin
                        req     = 1'b1;
                        state_n = WAIT;
                    end
                end
                DONE: state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod       <= '0;
            acc        <= '0;
            sample_cnt <= '0;
            lag        <= '0;
            next_add   <= 1'b0;
            corr_valid <= 1'b0;
            corr_out   <= '0;
            corr_lag   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            next_add   <= req;
            corr_valid <= emit;
            if (err_set) err <= 1'b1;
            if (take) begin
                prod       <= $signed(in_a) * $signed(in_b);
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (acc_step) acc <= acc + ACC_W'(prod);
            if (emit) begin
                corr_out   <= acc;
                corr_lag   <= lag;
                acc        <= '0;
                sample_cnt <= '0;
                if (lag == LAST_LAG) done <= 1'b1;
                else                 lag  <= lag + 1'b1;
            end
        end
    end

    corr_peak_tracker #(
        .ACC_W   (ACC_W),
        .LAG_W   (LAG_W),
        .RST_VAL ({1'b1, {(ACC_W-1){1'b0}}})
    ) u_peak (
        .clk      (clk),
        .rst      (rst),
        .upd      (emit),
        .value    (acc),
        .lag      (lag),
        .peak_val (peak_val),
        .peak_lag (peak_lag)
    );

endmodule

// File: tb/tb_corr_mac.sv
// tb/tb_corr_mac.sv - table and random vectors against a ROM model and arithmetic reference
module tb_corr_mac;

    localparam int NA = 4;
    localparam int NB = 6;
    localparam int NL = NB - NA + 1;
    localparam int AW = 24;
    localparam int LW = 13;
    localparam int NT = 6;

    logic          clk = 1'b0;
    logic          rst, ena_in, in_valid;
    logic [7:0]    in_a, in_b;
    logic          next_add, corr_valid, done, err;
    logic [AW-1:0] corr_out, peak_val;
    logic [LW-1:0] corr_lag, peak_lag;

    corr_mac #(.N_A(NA), .N_B(NB), .DATA_W(8), .ACC_W(AW), .LAG_W(LW)) dut (
        .clk(clk), .rst(rst), .ena_in(ena_in), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .next_add(next_add), .corr_valid(corr_valid),
        .corr_out(corr_out), .corr_lag(corr_lag), .peak_val(peak_val),
        .peak_lag(peak_lag), .done(done), .err(err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [NA-1:0][31:0] a;
        logic [NB-1:0][31:0] b;
        logic [NL-1:0][31:0] corr;
        logic [31:0]         pv;
        logic [31:0]         pl;
    } vec_t;

    vec_t tbl [NT];
    int   total = 0, bad = 0;
    int   rom_a [NA];
    int   rom_b [NB];
    int   got_corr [$];
    int   got_lag [$];
    int   n_req = 0, sent_cnt = 0, lat_bad = 0, stall_bad = 0, cyc = 0;
    int   inj_at = -1, stall_at = -1;
    logic lat_on = 1'b0;
    int   idx = 0, rlag = 0, delay = 2, last_send_cyc = 0, stall_left = 0;
    logic pend = 1'b1, bogus = 1'b0, last_final = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   s, pv, pl;
        r  = v;
        pv = -(1 << (AW - 1));
        pl = 0;
        for (int l = 0; l < NL; l++) begin
            s = 0;
            for (int i = 0; i < NA; i++) s += int'(v.a[i]) * int'(v.b[l + i]);
            r.corr[l] = s;
            if (s > pv) begin
                pv = s;
                pl = l;
            end
        end
        r.pv = pv;
        r.pl = pl;
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ROM model plus output monitor: first pair unprompted, then one pair per next_add
    initial begin
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        forever begin
            @(negedge clk);
            if (corr_valid) begin
                got_corr.push_back(int'($signed(corr_out)));
                got_lag.push_back(int'(corr_lag));
                if (lat_on && (cyc - last_send_cyc != 3)) lat_bad++;
            end
            if (next_add) begin
                n_req++;
                if (lat_on && (cyc - last_send_cyc != (last_final ? 3 : 2))) lat_bad++;
            end
            if (!ena_in && !rst && (next_add || corr_valid)) stall_bad++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) ena_in = 1'b1;
            end
            if (rst) begin
                idx = 0; rlag = 0; pend = 1'b1; delay = 2;
                in_valid = 1'b0; bogus = 1'b0; stall_left = 0;
                continue;
            end
            if (in_valid) begin
                in_valid = 1'b0;
                if (!bogus) begin
                    idx++;
                    if (idx == NA) begin
                        idx = 0;
                        rlag++;
                    end
                    if (sent_cnt == inj_at) begin
                        in_valid = 1'b1;
                        in_a     = 8'd100;
                        in_b     = 8'd100;
                    end
                    if (sent_cnt == stall_at) begin
                        ena_in     = 1'b0;
                        stall_left = 5;
                    end
                end
                bogus = in_valid;
            end
            if (next_add) pend = 1'b1;
            if (pend && ena_in && !in_valid) begin
                if (delay > 0) delay--;
                if (delay == 0) begin
                    in_valid      = 1'b1;
                    in_a          = 8'(rom_a[idx]);
                    in_b          = 8'(rom_b[rlag + idx]);
                    last_send_cyc = cyc;
                    last_final    = (idx == NA - 1);
                    sent_cnt++;
                    pend          = 1'b0;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, " corr_out"}, longint'(corr_out), 0);
        chk({tag, " corr_lag"}, longint'(corr_lag), 0);
        chk({tag, " peak_val"}, longint'($signed(peak_val)), -(longint'(1) << (AW - 1)));
        chk({tag, " peak_lag"}, longint'(peak_lag), 0);
        chk({tag, " done"}, longint'(done), 0);
        chk({tag, " err"}, longint'(err), 0);
        chk({tag, " corr_valid"}, longint'(corr_valid), 0);
        chk({tag, " next_add"}, longint'(next_add), 0);
    endtask

    task automatic clear_obs();
        got_corr.delete();
        got_lag.delete();
        n_req = 0; sent_cnt = 0; lat_bad = 0; stall_bad = 0;
    endtask

    task automatic start_run(input vec_t v, input int inj, input int stl, input logic lat);
        @(posedge clk); #2;
        rst    = 1'b1;
        ena_in = 1'b0;
        for (int i = 0; i < NA; i++) rom_a[i] = int'(v.a[i]);
        for (int i = 0; i < NB; i++) rom_b[i] = int'(v.b[i]);
        inj_at = inj; stall_at = stl; lat_on = lat;
        @(posedge clk); #2;
        clear_obs();
        rst    = 1'b0;
        ena_in = 1'b1;
    endtask

    task automatic check_run(input string tag, input vec_t v, input int exp_err);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        chk({tag, " done"}, longint'(done), 1);
        repeat (4) begin
            @(posedge clk); #2;
        end
        chk({tag, " n_corr"}, got_corr.size(), NL);
        for (int l = 0; l < NL && l < got_corr.size(); l++) begin
            chk($sformatf("%s corr[%0d]", tag, l), got_corr[l], longint'(int'(v.corr[l])));
            chk($sformatf("%s lag[%0d]", tag, l), got_lag[l], l);
        end
        chk({tag, " peak_val"}, longint'($signed(peak_val)), longint'(int'(v.pv)));
        chk({tag, " peak_lag"}, longint'(peak_lag), longint'(int'(v.pl)));
        chk({tag, " err"}, longint'(err), exp_err);
        chk({tag, " next_add_cnt"}, n_req, NA * NL - 1);
        chk({tag, " stall_pulses"}, stall_bad, 0);
        if (lat_on) chk({tag, " latency"}, lat_bad, 0);
    endtask

    initial begin
        int b0 [NB];
        int n;
        b0     = '{1, 0, 0, 0, 1, 2};
        rst    = 1'b1;
        ena_in = 1'b0;

        for (int i = 0; i < NA; i++) tbl[0].a[i] = 32'(i + 1);
        for (int i = 0; i < NB; i++) tbl[0].b[i] = 32'(b0[i]);
        tbl[0].corr[0] = 32'(1);
        tbl[0].corr[1] = 32'(4);
        tbl[0].corr[2] = 32'(11);
        tbl[0].pv      = 32'(11);
        tbl[0].pl      = 32'(2);
        for (int i = 0; i < NA; i++) tbl[1].a[i] = 32'(-128);
        for (int i = 0; i < NB; i++) tbl[1].b[i] = 32'(127);
        for (int l = 0; l < NL; l++) tbl[1].corr[l] = 32'(-65024);
        tbl[1].pv = 32'(-65024);
        tbl[1].pl = 32'(0);
        for (int t = 2; t < NT; t++) begin
            for (int i = 0; i < NA; i++) tbl[t].a[i] = 32'(int'($urandom_range(255)) - 128);
            for (int i = 0; i < NB; i++) tbl[t].b[i] = 32'(int'($urandom_range(255)) - 128);
            tbl[t] = model(tbl[t]);
        end

        repeat (2) @(posedge clk);
        #2;
        check_reset("reset");

        for (int t = 0; t < NT; t++) begin
            start_run(tbl[t], -1, -1, 1'b1);
            check_run($sformatf("vec%0d", t), tbl[t], 0);
        end

        start_run(tbl[0], -1, 6, 1'b0);
        check_run("stall", tbl[0], 0);

        start_run(tbl[0], 6, -1, 1'b0);
        check_run("proterr", tbl[0], 1);

        start_run(tbl[0], -1, -1, 1'b0);
        n = 0;
        while (sent_cnt < NA + 2 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("midrst reached", sent_cnt, NA + 2);
        repeat (2) begin
            @(posedge clk); #2;
        end
        rst = 1'b1;
        @(posedge clk); #2;
        check_reset("midrst");
        clear_obs();
        rst = 1'b0;
        check_run("rerun", tbl[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
